// File: rtl/mfp_serial_spi.sv
// mfp_serial_spi: mode-0 SPI slave for the io-controller end of the MFP serial link.
// Pops the MFP UART output FIFO, pushes the MFP UART input FIFO and returns the
// 64-bit serial status word. SCK/SS/MOSI are oversampled in the clk domain.
// Optional build macro MFP_SPI_STATUS_LATCH_EN: snapshot the status word when a
// status command is decoded so all 8 status bytes come from one coherent sample.
module mfp_serial_spi #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter logic [7:0]  CMD_STATUS  = 8'h10,
    parameter logic [7:0]  CMD_READ    = 8'h11,
    parameter logic [7:0]  CMD_WRITE   = 8'h12
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        spi_sck,
    input  logic        spi_ss_n,
    input  logic        spi_mosi,
    output logic        spi_miso,
    input  logic        serial_data_out_available,
    input  logic [7:0]  serial_data_out,
    output logic        serial_strobe_out,
    input  logic [63:0] serial_status_out,
    output logic [7:0]  serial_data_in,
    output logic        serial_strobe_in,
    input  logic        serial_data_in_full
);

    typedef enum logic [2:0] {
        StIdle,
        StCmd,
        StStatus,
        StRead,
        StWrite,
        StIgnore
    } state_e;

    state_e state_q, state_d;

    logic [SYNC_STAGES-1:0] sck_sync_q, ss_sync_q, mosi_sync_q;
    logic                   sck_prev_q;
    logic                   sck_s, ss_n_s, mosi_s;
    logic                   sck_rise, sck_fall;

    logic       armed_q;
    logic [2:0] bit_cnt_q;
    logic [3:0] byte_idx_q;
    logic [6:0] rx_q;
    logic [7:0] rx_byte;
    logic       byte_done;
    logic [7:0] tx_q;
    logic       valid_q;
    logic       ld1_q, ld2_q;
    logic       strobe_out_q, strobe_in_q;
    logic [7:0] data_in_q;

    logic [63:0] status_src;
    logic [7:0]  status_byte;

    assign sck_s  = sck_sync_q[SYNC_STAGES-1];
    assign ss_n_s = ss_sync_q[SYNC_STAGES-1];
    assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

    assign sck_rise  = sck_s & ~sck_prev_q;
    assign sck_fall  = ~sck_s & sck_prev_q;
    assign byte_done = sck_rise && (bit_cnt_q == 3'd7);
    assign rx_byte   = {rx_q, mosi_s};

    // Input synchronisers and SCK edge history. The SS chain resets low so a
    // transfer already in flight at reset is not mistaken for a fresh deselect.
    always_ff @(posedge clk) begin
        if (reset) begin
            sck_sync_q  <= '0;
            ss_sync_q   <= '0;
            mosi_sync_q <= '0;
            sck_prev_q  <= 1'b0;
        end else begin
            sck_sync_q  <= {sck_sync_q[SYNC_STAGES-2:0], spi_sck};
            ss_sync_q   <= {ss_sync_q[SYNC_STAGES-2:0], spi_ss_n};
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi};
            sck_prev_q  <= sck_s;
        end
    end

    // Arm once SS has been seen high, so a transaction cut by reset is ignored.
    always_ff @(posedge clk) begin
        if (reset) begin
            armed_q <= 1'b0;
        end else if (ss_n_s) begin
            armed_q <= 1'b1;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: command decode on the first byte, deselect always wins.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (armed_q && !ss_n_s) begin
                    state_d = StCmd;
                end
            end
            StCmd: begin
                if (byte_done) begin
                    if (rx_byte == CMD_STATUS) begin
                        state_d = StStatus;
                    end else if (rx_byte == CMD_READ) begin
                        state_d = StRead;
                    end else if (rx_byte == CMD_WRITE) begin
                        state_d = StWrite;
                    end else begin
                        state_d = StIgnore;
                    end
                end
            end
            StStatus, StRead, StWrite, StIgnore: ;
            default: state_d = StIdle;
        endcase
        if (ss_n_s) begin
            state_d = StIdle;
        end
    end

`ifdef MFP_SPI_STATUS_LATCH_EN
    logic [63:0] status_snap_q;

    // Capture the whole status word as the status command is accepted.
    always_ff @(posedge clk) begin
        if (reset) begin
            status_snap_q <= '0;
        end else if (state_q == StCmd && state_d == StStatus) begin
            status_snap_q <= serial_status_out;
        end
    end

    assign status_src = status_snap_q;
`else
    assign status_src = serial_status_out;
`endif

    // Select status byte k (MSB first); index 8 means past the end and reads zero.
    always_comb begin
        status_byte = 8'h00;
        for (int k = 0; k < 8; k++) begin
            if (byte_idx_q == 4'(k)) begin
                status_byte = status_src[63 - 8*k -: 8];
            end
        end
    end

    // Datapath: bit/byte counters, shift registers, load pipeline and strobes.
    // READ loads one clk later than STATUS so the FIFO pop issued on the same
    // byte boundary has already advanced the head byte.
    always_ff @(posedge clk) begin
        if (reset) begin
            bit_cnt_q    <= 3'd0;
            byte_idx_q   <= 4'd0;
            rx_q         <= 7'd0;
            tx_q         <= 8'h00;
            valid_q      <= 1'b0;
            ld1_q        <= 1'b0;
            ld2_q        <= 1'b0;
            strobe_out_q <= 1'b0;
            strobe_in_q  <= 1'b0;
            data_in_q    <= 8'h00;
        end else begin
            strobe_out_q <= 1'b0;
            strobe_in_q  <= 1'b0;
            ld1_q        <= 1'b0;
            ld2_q        <= ld1_q;
            if (state_q == StIdle) begin
                bit_cnt_q  <= 3'd0;
                byte_idx_q <= 4'd0;
                tx_q       <= 8'h00;
                valid_q    <= 1'b0;
            end else begin
                if (sck_rise) begin
                    bit_cnt_q <= bit_cnt_q + 3'd1;
                    rx_q      <= rx_byte[6:0];
                end
                // No shift on the fall that follows a byte boundary: the MSB of
                // the freshly loaded byte must survive until the next rise.
                if (sck_fall && bit_cnt_q != 3'd0) begin
                    tx_q <= {tx_q[6:0], 1'b0};
                end
                if (byte_done && !ss_n_s) begin
                    if (state_q == StRead && valid_q) begin
                        strobe_out_q <= 1'b1;
                    end
                    if (state_q == StWrite && !serial_data_in_full) begin
                        data_in_q   <= rx_byte;
                        strobe_in_q <= 1'b1;
                    end
                    if (state_d == StStatus || state_d == StRead) begin
                        ld1_q <= 1'b1;
                    end
                end
                if (ld1_q && state_q == StStatus) begin
                    tx_q <= status_byte;
                    if (byte_idx_q != 4'd8) begin
                        byte_idx_q <= byte_idx_q + 4'd1;
                    end
                end
                if (ld2_q && state_q == StRead) begin
                    valid_q <= serial_data_out_available;
                    tx_q    <= serial_data_out_available ? serial_data_out : 8'h00;
                end
            end
        end
    end

    assign spi_miso          = (state_q == StStatus || state_q == StRead) ? tx_q[7] : 1'b0;
    assign serial_strobe_out = strobe_out_q;
    assign serial_strobe_in  = strobe_in_q;
    assign serial_data_in    = data_in_q;

endmodule

// File: tb/tb_mfp_serial_spi.sv
// tb_mfp_serial_spi: directed SPI-master transactions against mfp_serial_spi with
// a FIFO/status model; set MFP_SPI_STATUS_LATCH_EN to match the RTL build.
module tb_mfp_serial_spi;

    localparam int SYNC = 2;
    localparam int HALF = 8;  // clk cycles per SCK half period (SCK = clk/16)
`ifdef MFP_SPI_STATUS_LATCH_EN
    localparam bit LATCH = 1'b1;
`else
    localparam bit LATCH = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        spi_sck, spi_ss_n, spi_mosi, spi_miso;
    logic        serial_data_out_available;
    logic [7:0]  serial_data_out;
    logic        serial_strobe_out;
    logic [63:0] serial_status_out;
    logic [7:0]  serial_data_in;
    logic        serial_strobe_in;
    logic        serial_data_in_full;

    always #5 clk = ~clk;

    mfp_serial_spi #(.SYNC_STAGES(SYNC)) dut (
        .clk                       (clk),
        .reset                     (reset),
        .spi_sck                   (spi_sck),
        .spi_ss_n                  (spi_ss_n),
        .spi_mosi                  (spi_mosi),
        .spi_miso                  (spi_miso),
        .serial_data_out_available (serial_data_out_available),
        .serial_data_out           (serial_data_out),
        .serial_strobe_out         (serial_strobe_out),
        .serial_status_out         (serial_status_out),
        .serial_data_in            (serial_data_in),
        .serial_strobe_in          (serial_strobe_in),
        .serial_data_in_full       (serial_data_in_full)
    );

    int vectors = 0;
    int miscompares = 0;

    logic [7:0] out_fifo[$];   // model of the MFP output FIFO contents
    logic [7:0] in_log[$];     // bytes pushed into the MFP input FIFO
    int         pops = 0;
    logic [63:0] status_new;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic refresh_fifo();
        serial_data_out_available = (out_fifo.size() != 0);
        serial_data_out = (out_fifo.size() != 0) ? out_fifo[0] : 8'h00;
    endtask

    // Status byte k as an SPI master sees it: big-endian, zero past byte 7.
    function automatic logic [7:0] model_status(input logic [63:0] w, input int k);
        if (k > 7) return 8'h00;
        return 8'((w >> (8 * (7 - k))) & 64'hff);
    endfunction

    // Per-cycle compare: pop/push pulses, FIFO model, idle MISO.
    logic so_prev = 1'b0, si_prev = 1'b0;
    int   ss_high_cnt = 0;
    always @(negedge clk) begin
        if (reset) begin
            so_prev = 1'b0;
            si_prev = 1'b0;
        end else begin
            if (serial_strobe_out) begin
                check("pop_width", 64'(so_prev), 64'd0);
                check("pop_nonempty", 64'(out_fifo.size() != 0), 64'd1);
                if (out_fifo.size() != 0) void'(out_fifo.pop_front());
                pops++;
                refresh_fifo();
            end
            if (serial_strobe_in) begin
                check("push_width", 64'(si_prev), 64'd0);
                in_log.push_back(serial_data_in);
            end
            so_prev = serial_strobe_out;
            si_prev = serial_strobe_in;
        end
        ss_high_cnt = spi_ss_n ? ss_high_cnt + 1 : 0;
        if (ss_high_cnt > SYNC + 3) check("miso_idle", 64'(spi_miso), 64'd0);
    end

    // One SPI byte (or nbits of it), mode 0, MSB first. change_mid applies
    // status_new to the status input part way through this byte.
    task automatic xfer(input logic [7:0] tx, input int nbits, input bit change_mid,
                        output logic [7:0] rx);
        rx = 8'h00;
        for (int i = 0; i < nbits; i++) begin
            spi_mosi = tx[7-i];
            repeat (HALF) @(negedge clk);
            spi_sck = 1'b1;
            rx = {rx[6:0], spi_miso};
            if (change_mid && i == 3) serial_status_out = status_new;
            repeat (HALF) @(negedge clk);
            spi_sck = 1'b0;
        end
    endtask

    task automatic select();
        spi_ss_n = 1'b0;
        repeat (HALF) @(negedge clk);
    endtask

    task automatic deselect();
        repeat (HALF) @(negedge clk);
        spi_ss_n = 1'b1;
        repeat (4 * HALF) @(negedge clk);
    endtask

    // Status transaction; status changes to w_after during byte change_at (-1: never).
    task automatic status_txn(input logic [63:0] w, input logic [63:0] w_after,
                              input int nbytes, input int change_at, input string tag);
        logic [7:0] rx;
        logic [63:0] src;
        int pops0;
        pops0 = pops;
        serial_status_out = w;
        status_new = w_after;
        select();
        xfer(8'h10, 8, 1'b0, rx);
        check({tag, "_cmd_miso"}, 64'(rx), 64'd0);
        for (int k = 0; k < nbytes; k++) begin
            xfer(8'h00, 8, (k == change_at), rx);
            src = (change_at >= 0 && k > change_at && !LATCH) ? w_after : w;
            check($sformatf("%s_byte%0d", tag, k), 64'(rx), 64'(model_status(src, k)));
        end
        deselect();
        check({tag, "_no_pop"}, 64'(pops), 64'(pops0));
    endtask

    // Read transaction; expected bytes come from a snapshot of the FIFO model.
    task automatic read_txn(input int nbytes, input string tag);
        logic [7:0] rx;
        logic [7:0] snap[$];
        int exp_pops;
        snap = out_fifo;
        exp_pops = pops + ((snap.size() < nbytes) ? snap.size() : nbytes);
        select();
        xfer(8'h11, 8, 1'b0, rx);
        check({tag, "_cmd_miso"}, 64'(rx), 64'd0);
        for (int k = 0; k < nbytes; k++) begin
            xfer(8'h00, 8, 1'b0, rx);
            check($sformatf("%s_byte%0d", tag, k), 64'(rx),
                  64'((k < snap.size()) ? snap[k] : 8'h00));
        end
        deselect();
        check({tag, "_pops"}, 64'(pops), 64'(exp_pops));
    endtask

    logic [7:0]  rx;
    logic [71:0] lit;
    int          pops0;

    initial begin
        reset = 1'b1;
        spi_sck = 1'b0;
        spi_ss_n = 1'b1;
        spi_mosi = 1'b0;
        serial_status_out = 64'h0;
        serial_data_in_full = 1'b0;
        status_new = 64'h0;
        refresh_fifo();
        repeat (5) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("rst_miso", 64'(spi_miso), 64'd0);
        check("rst_strobe_out", 64'(serial_strobe_out), 64'd0);
        check("rst_strobe_in", 64'(serial_strobe_in), 64'd0);
        check("rst_data_in", 64'(serial_data_in), 64'd0);
        repeat (4 * HALF) @(negedge clk);

        // Status read, with hand-computed bytes pinning the model.
        serial_status_out = 64'h0000_2580_0800_0001;
        lit = 72'h00_00_25_80_08_00_00_01_00;
        select();
        xfer(8'h10, 8, 1'b0, rx);
        check("st_cmd_miso", 64'(rx), 64'd0);
        for (int k = 0; k < 9; k++) begin
            xfer(8'h00, 8, 1'b0, rx);
            check($sformatf("st_lit%0d", k), 64'(rx), 64'(lit[71 - 8*k -: 8]));
        end
        deselect();
        check("st_no_pop", 64'(pops), 64'd0);
        check("st_no_push", 64'(in_log.size()), 64'd0);

        // Read one byte: 0x41, exactly one pop after the data byte.
        out_fifo.push_back(8'h41);
        refresh_fifo();
        select();
        xfer(8'h11, 8, 1'b0, rx);
        check("rd_cmd_miso", 64'(rx), 64'd0);
        check("rd_no_pop_yet", 64'(pops), 64'd0);
        xfer(8'h00, 8, 1'b0, rx);
        check("rd_byte", 64'(rx), 64'h41);
        deselect();
        check("rd_one_pop", 64'(pops), 64'd1);

        // Read several bytes through pops, then one past empty.
        out_fifo.push_back(8'h42);
        out_fifo.push_back(8'h43);
        out_fifo.push_back(8'h44);
        refresh_fifo();
        read_txn(4, "rd3");

        // Read with empty FIFO: zeros, no pops.
        pops0 = pops;
        read_txn(2, "rd_empty");
        check("rd_empty_pops_lit", 64'(pops - pops0), 64'd0);

        // Write 0x55, then 0xAA with the input FIFO full.
        in_log.delete();
        select();
        xfer(8'h12, 8, 1'b0, rx);
        check("wr_cmd_miso", 64'(rx), 64'd0);
        xfer(8'h55, 8, 1'b0, rx);
        check("wr_b0_miso", 64'(rx), 64'd0);
        serial_data_in_full = 1'b1;
        xfer(8'hAA, 8, 1'b0, rx);
        check("wr_b1_miso", 64'(rx), 64'd0);
        deselect();
        serial_data_in_full = 1'b0;
        check("wr_push_count", 64'(in_log.size()), 64'd1);
        check("wr_push_data", 64'((in_log.size() != 0) ? in_log[0] : 8'hxx), 64'h55);

        // Abort mid-byte: no push; next status transaction is normal.
        in_log.delete();
        select();
        xfer(8'h12, 8, 1'b0, rx);
        xfer(8'h77, 5, 1'b0, rx);
        spi_ss_n = 1'b1;
        repeat (4 * HALF) @(negedge clk);
        check("abort_no_push", 64'(in_log.size()), 64'd0);
        status_txn(64'h0123_4567_89AB_CDEF, 64'h0, 8, -1, "post_abort");

        // Reset mid-transfer: rest of transaction ignored until reselect.
        in_log.delete();
        select();
        xfer(8'h12, 8, 1'b0, rx);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        xfer(8'h66, 8, 1'b0, rx);
        deselect();
        check("rst_mid_no_push", 64'(in_log.size()), 64'd0);
        select();
        xfer(8'h12, 8, 1'b0, rx);
        xfer(8'h5A, 8, 1'b0, rx);
        deselect();
        check("rst_after_push_count", 64'(in_log.size()), 64'd1);
        check("rst_after_push_data", 64'((in_log.size() != 0) ? in_log[0] : 8'hxx), 64'h5A);

        // Status word changes during byte 2: latched build keeps the old word.
        status_txn(64'h1122_3344_5566_7788, 64'h99AA_BBCC_DDEE_FF00, 9, 2, "latch");

        // Unknown command: MISO stays low, no strobes.
        pops0 = pops;
        in_log.delete();
        out_fifo.push_back(8'h99);
        refresh_fifo();
        select();
        xfer(8'h3C, 8, 1'b0, rx);
        xfer(8'h00, 8, 1'b0, rx);
        check("ign_miso", 64'(rx), 64'd0);
        deselect();
        check("ign_no_pop", 64'(pops), 64'(pops0));
        check("ign_no_push", 64'(in_log.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
